pwm_duty_ctrl: RTL and testbench

- Sequencer for an 8-bit free-running PWM generator (256-cycle period, output high while counter < duty).
- Owns the period counter and drives the generator's duty input. Duty changes only at period boundaries, so the PWM output never glitches mid-period.
- Accepts duty commands over a valid/ready handshake. Each command either loads its duty immediately at the next boundary or ramps toward it in fixed steps.

---
 rtl/pwm_duty_ctrl_if.sv | 10 +
 rtl/pwm_duty_ctrl.sv | 118 +++++++++++
 tb/tb_pwm_duty_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ctrl_if.sv
// Command handshake bundle for pwm_duty_ctrl: target duty and ramp/immediate mode.
interface pwm_duty_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_duty;
  logic       cmd_ramp;

  modport master (output cmd_valid, output cmd_duty, output cmd_ramp, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_duty, input cmd_ramp, output cmd_ready);
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Period counter and boundary-synchronous duty sequencer for an 8-bit PWM generator.
// Optional macro PWM_DUTY_CTRL_RETARGET_EN: accept new commands while ramping.
module pwm_duty_ctrl #(
  parameter int unsigned RAMP_STEP        = 1,
  parameter int unsigned PERIODS_PER_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_duty_ctrl_if.slave cmd,
  output logic [7:0]    duty_out,
  output logic [7:0]    pwm_cnt,
  output logic          period_start,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;

  localparam logic [7:0] STEP_LAST = 8'(PERIODS_PER_STEP - 1);
  localparam logic [8:0] STEP9     = 9'(RAMP_STEP);

  state_t     state, state_next;
  logic [7:0] target, target_next;
  logic [7:0] step_cnt, step_next;
  logic [7:0] duty_next;
  logic       done_next;
  logic       boundary;
  logic       accept;
  logic [8:0] up_sum, dn_diff;
  logic [7:0] ramped;

  assign boundary     = (pwm_cnt == 8'hFF);
  assign period_start = (pwm_cnt == 8'h00);
  assign busy         = (state != IDLE);
  assign accept       = cmd.cmd_valid & cmd.cmd_ready;

`ifdef PWM_DUTY_CTRL_RETARGET_EN
  assign cmd.cmd_ready = (state == IDLE) || (state == RAMP);
`else
  assign cmd.cmd_ready = (state == IDLE);
`endif

  // 9-bit arithmetic so a step can neither overshoot the target nor wrap.
  always_comb begin
    up_sum  = {1'b0, duty_out} + STEP9;
    dn_diff = {1'b0, duty_out} - STEP9;
    if (target > duty_out)
      ramped = (up_sum >= {1'b0, target}) ? target : up_sum[7:0];
    else
      ramped = (dn_diff[8] || (dn_diff[7:0] <= target)) ? target : dn_diff[7:0];
  end

  always_comb begin
    state_next  = state;
    duty_next   = duty_out;
    target_next = target;
    step_next   = step_cnt;
    done_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          target_next = cmd.cmd_duty;
          step_next   = '0;
          state_next  = cmd.cmd_ramp ? RAMP : LOAD;
        end
      end
      LOAD: begin
        if (boundary) begin
          duty_next  = target;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      RAMP: begin
`ifdef PWM_DUTY_CTRL_RETARGET_EN
        // A retarget takes priority over a coincident boundary step.
        if (accept) begin
          target_next = cmd.cmd_duty;
          step_next   = '0;
          state_next  = cmd.cmd_ramp ? RAMP : LOAD;
        end else
`endif
        if (boundary) begin
          if (step_cnt == STEP_LAST) begin
            step_next = '0;
            duty_next = ramped;
            if (ramped == target) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end else begin
            step_next = step_cnt + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pwm_cnt  <= '0;
      duty_out <= '0;
      target   <= '0;
      step_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      pwm_cnt  <= pwm_cnt + 8'd1;
      duty_out <= duty_next;
      target   <= target_next;
      step_cnt <= step_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl: directed and random commands against a per-boundary duty model.
module tb_pwm_duty_ctrl;
  localparam int STEP = 3;
  localparam int PPS  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] duty_out, pwm_cnt;
  logic       period_start, busy, done;

  pwm_duty_ctrl_if cmd_if ();

  pwm_duty_ctrl #(.RAMP_STEP(STEP), .PERIODS_PER_STEP(PPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if.slave),
    .duty_out     (duty_out),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_duty = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected duty_out after each boundary following acceptance, last entry completes the command.
  function automatic void build(input int cur, input int tgt, input bit ramp);
    int d;
    int k;
    exp_q.delete();
    if (!ramp) begin
      exp_q.push_back(tgt);
      return;
    end
    d = cur;
    k = 0;
    forever begin
      k++;
      if (k % PPS == 0) begin
        if (tgt > d) d = (d + STEP > tgt) ? tgt : d + STEP;
        else         d = (d - STEP < tgt) ? tgt : d - STEP;
      end
      exp_q.push_back(d);
      if (k % PPS == 0 && d == tgt) break;
    end
  endfunction

  task automatic start_cmd(input int d, input bit r, input int acc);
    int n;
    n = 0;
    while (pwm_cnt != 8'(acc) && n < 600) begin
      tick();
      n++;
    end
    chk("accept_wait_bound", 32'(n < 600), 1);
    chk("ready_before_accept", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = 8'(d);
    cmd_if.cmd_ramp  = r;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
`ifdef PWM_DUTY_CTRL_RETARGET_EN
    chk("ready_after_accept", cmd_if.cmd_ready, 32'(r));
`else
    chk("ready_after_accept", cmd_if.cmd_ready, 0);
`endif
    if (pwm_cnt == 8'd0) begin
      chk("skipped_boundary_duty", duty_out, 32'(model_duty));
      chk("skipped_boundary_done", done, 0);
    end
    build(model_duty, d, r);
  endtask

  task automatic next_boundary();
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (pwm_cnt != 8'd0) begin
        chk("mid_period_duty", duty_out, 32'(model_duty));
        chk("mid_period_done", done, 0);
        chk("mid_period_start", period_start, 0);
      end
    end while (pwm_cnt != 8'd0 && n < 300);
    chk("boundary_wait_bound", 32'(n < 300), 1);
  endtask

  task automatic follow(input int limit);
    int cnt;
    cnt = 0;
    while (exp_q.size() > 0 && (limit < 0 || cnt < limit)) begin
      next_boundary();
      model_duty = exp_q.pop_front();
      chk("boundary_start", period_start, 1);
      chk("boundary_duty", duty_out, 32'(model_duty));
      chk("boundary_done", done, 32'(exp_q.size() == 0));
      cnt++;
    end
    if (exp_q.size() == 0) begin
      tick();
      chk("post_done_low", done, 0);
      chk("post_ready", cmd_if.cmd_ready, 1);
      chk("post_busy", busy, 0);
    end
  endtask

  task automatic run_cmd(input int d, input bit r, input int acc);
    start_cmd(d, r, acc);
    follow(-1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int starts;
    int d;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_duty  = '0;
    cmd_if.cmd_ramp  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_cnt", pwm_cnt, 0);
    chk("rst_duty", duty_out, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", period_start, 1);
    @(negedge clk) rst_n = 1'b1;

    starts = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      chk("free_count", pwm_cnt, 32'((i + 1) % 256));
      chk("free_duty", duty_out, 0);
      if (period_start) starts++;
    end
    chk("period_start_count", 32'(starts), 2);

    // Reset mid-ramp, after the second ramp step has landed.
    start_cmd(20, 1'b1, 10);
    follow(4);
    chk("pre_reset_duty", duty_out, 6);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_duty", duty_out, 0);
    chk("async_rst_cnt", pwm_cnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cmd_if.cmd_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    model_duty = 0;
    exp_q.delete();
    tick();
    chk("post_reset_cnt", pwm_cnt, 1);

    run_cmd(10, 1'b0, 100);
    run_cmd(30, 1'b1, 7);
    run_cmd(0, 1'b1, 200);
    run_cmd(50, 1'b0, 255);
    run_cmd(50, 1'b1, 40);
    run_cmd(49, 1'b1, 128);
    run_cmd(255, 1'b0, 3);
    run_cmd(252, 1'b1, 254);

`ifdef PWM_DUTY_CTRL_RETARGET_EN
    start_cmd(230, 1'b1, 5);
    follow(1);
    start_cmd(251, 1'b1, 60);
    follow(-1);
    start_cmd(200, 1'b1, 20);
    follow(1);
    start_cmd(100, 1'b0, 90);
    follow(-1);
`endif

    for (int k = 0; k < 6; k++) begin
      d = model_duty + int'($urandom_range(0, 48)) - 24;
      if (d < 0) d = 0;
      if (d > 255) d = 255;
      run_cmd(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
